// File: rtl/btn_debounce_repeat.sv
// Button conditioning: 2-FF sync, debounce and hold-to-repeat step pulses for the
// active-low up/down buttons. Channel index 0 is up, 1 is down.
module btn_debounce_repeat #(
    parameter int unsigned DB_CYCLES     = 1000000,
    parameter int unsigned REPEAT_DELAY  = 13500000,
    parameter int unsigned REPEAT_PERIOD = 2700000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic up_raw,
    input  logic down_raw,
    output logic up_lvl,
    output logic down_lvl,
    output logic up_pulse,
    output logic down_pulse
);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

    localparam logic [CNT_W-1:0] DbLast     = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);

    logic [1:0]       raw;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       lvl_q, lvl_d;
    logic [1:0]       pulse;
    logic             both_low;
    logic [CNT_W-1:0] db_cnt_q [2];
    logic [CNT_W-1:0] db_cnt_d [2];
    logic [CNT_W-1:0] tmr_q [2];
    logic [CNT_W-1:0] tmr_d [2];
    state_e           state_q [2];
    state_e           state_d [2];

    assign raw = {down_raw, up_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            lvl_q   <= '1;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
                tmr_q[i]    <= '0;
                state_q[i]  <= StIdle;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                tmr_q[i]    <= tmr_d[i];
                state_q[i]  <= state_d[i];
            end
        end
    end

    always_comb begin
        lvl_d = lvl_q;
        pulse = '0;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            tmr_d[i]    = '0;
            state_d[i]  = state_q[i];

            if (sync2_q[i] != lvl_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    lvl_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
            end

            // Release wins over any pending expiry: it never produces a pulse.
            if (lvl_q[i]) begin
                state_d[i] = StIdle;
            end else begin
                unique case (state_q[i])
                    StIdle: begin
                        pulse[i]   = 1'b1;
                        state_d[i] = StDelay;
                    end
                    StDelay: begin
                        if (tmr_q[i] == DelayLast) begin
                            pulse[i]   = 1'b1;
                            state_d[i] = StRepeat;
                        end else begin
                            tmr_d[i] = tmr_q[i] + CNT_W'(1);
                        end
                    end
                    StRepeat: begin
                        if (tmr_q[i] == PeriodLast) begin
                            pulse[i] = 1'b1;
                        end else begin
                            tmr_d[i] = tmr_q[i] + CNT_W'(1);
                        end
                    end
                    default: state_d[i] = StIdle;
                endcase
            end
        end
    end

    // Both buttons down suppresses stepping; timers keep running underneath.
    assign both_low   = ~lvl_q[0] & ~lvl_q[1];
    assign up_lvl     = lvl_q[0];
    assign down_lvl   = lvl_q[1];
    assign up_pulse   = pulse[0] & ~both_low;
    assign down_pulse = pulse[1] & ~both_low;

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Self-checking bench for btn_debounce_repeat: directed scenarios with literal
// expectations plus randomized button activity against a window/arithmetic model.
module tb_btn_debounce_repeat;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 5;
    localparam int unsigned W  = 8;
    localparam int H = DB + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic up_raw = 1'b1;
    logic down_raw = 1'b1;
    logic up_lvl, down_lvl, up_pulse, down_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_debounce_repeat #(
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .CNT_W        (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_raw    (up_raw),
        .down_raw  (down_raw),
        .up_lvl    (up_lvl),
        .down_lvl  (down_lvl),
        .up_pulse  (up_pulse),
        .down_pulse(down_pulse)
    );

    // Model: hist[c][0] is the raw value sampled at the latest edge. A level is
    // accepted once the DB samples taken 2..DB+1 edges ago all agree on a new value.
    // Pulses fall at offsets 0, RD, RD+RP, RD+2RP ... from the press cycle.
    bit hist [2][H];
    bit m_lvl [2];
    bit m_pulse [2];
    int t0 [2];
    int cyc;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < H; i++) hist[c][i] = 1'b1;
            m_lvl[c]   = 1'b1;
            m_pulse[c] = 1'b0;
            t0[c]      = 0;
        end
    endtask

    task automatic model_step();
        bit rawv [2];
        bit stable;
        int d;
        rawv[0] = up_raw;
        rawv[1] = down_raw;
        cyc++;
        for (int c = 0; c < 2; c++) begin
            for (int i = H - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
            hist[c][0] = rawv[c];
            stable = 1'b1;
            for (int i = 2; i < H; i++) if (hist[c][i] != hist[c][2]) stable = 1'b0;
            if (stable && hist[c][2] != m_lvl[c]) begin
                m_lvl[c] = hist[c][2];
                if (!m_lvl[c]) t0[c] = cyc;
            end
        end
        for (int c = 0; c < 2; c++) begin
            d = cyc - t0[c];
            m_pulse[c] = !m_lvl[c] && (d == 0 || (d >= RD && (d - RD) % RP == 0));
        end
        if (!m_lvl[0] && !m_lvl[1]) begin
            m_pulse[0] = 1'b0;
            m_pulse[1] = 1'b0;
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        check("up_lvl",     up_lvl,     m_lvl[0]);
        check("down_lvl",   down_lvl,   m_lvl[1]);
        check("up_pulse",   up_pulse,   m_pulse[0]);
        check("down_pulse", down_pulse, m_pulse[1]);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int up_cnt, dn_cnt, lvl_low_cnt;

        // Reset with both buttons held down.
        #1;
        rst_n = 1'b0;
        up_raw = 1'b0;
        down_raw = 1'b0;
        tick(3);
        check("rst_up_lvl", up_lvl, 1'b1);
        check("rst_down_lvl", down_lvl, 1'b1);
        check("rst_up_pulse", up_pulse, 1'b0);
        rst_n = 1'b1;
        tick(5);
        check("rst_hold_up_lvl", up_lvl, 1'b1);
        check("rst_hold_down_lvl", down_lvl, 1'b1);
        tick(1);
        check("rst_fall_up_lvl", up_lvl, 1'b0);
        check("rst_fall_down_lvl", down_lvl, 1'b0);
        up_raw = 1'b1;
        down_raw = 1'b1;
        tick(12);

        // Clean press held 40 cycles.
        up_raw = 1'b0;
        tick(5);
        check("press_lvl_before", up_lvl, 1'b1);
        tick(1);
        check("press_lvl_after", up_lvl, 1'b0);
        check("press_first_pulse", up_pulse, 1'b1);
        up_cnt = 1;
        dn_cnt = 0;
        for (int k = 7; k <= 50; k++) begin
            tick(1);
            up_cnt += int'(up_pulse);
            dn_cnt += int'(down_pulse);
            if (k == 15) check("press_no_pulse_15", up_pulse, 1'b0);
            if (k == 16) check("press_first_repeat", up_pulse, 1'b1);
            if (k == 40) up_raw = 1'b1;
        end
        check_int("press_up_pulses", up_cnt, 7);
        check_int("press_down_pulses", dn_cnt, 0);
        check("press_released", up_lvl, 1'b1);
        tick(5);

        // Bounce: runs of 3, 2, 3 never reach the debounce length.
        up_cnt = 0;
        lvl_low_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 1 || k == 6) up_raw = 1'b0;
            if (k == 4 || k == 9) up_raw = 1'b1;
            tick(1);
            up_cnt += int'(up_pulse);
            lvl_low_cnt += int'(!up_lvl);
        end
        check_int("bounce_pulses", up_cnt, 0);
        check_int("bounce_lvl_low", lvl_low_cnt, 0);

        // Short tap on down.
        down_raw = 1'b0;
        dn_cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            dn_cnt += int'(down_pulse);
            if (k == 8) down_raw = 1'b1;
            if (k == 13) check("tap_lvl_still_low", down_lvl, 1'b0);
            if (k == 14) check("tap_lvl_released", down_lvl, 1'b1);
        end
        check_int("tap_down_pulses", dn_cnt, 1);

        // Both held: pulses masked, up resumes on its repeat schedule.
        up_raw = 1'b0;
        up_cnt = 0;
        dn_cnt = 0;
        for (int k = 1; k <= 80; k++) begin
            tick(1);
            up_cnt += int'(up_pulse);
            dn_cnt += int'(down_pulse);
            if (k == 3) down_raw = 1'b0;
            if (k == 33) down_raw = 1'b1;
            if (k == 63) up_raw = 1'b1;
            if (k == 20) check("both_down_lvl", down_lvl, 1'b0);
            if (k == 36) check("both_masked_36", up_pulse, 1'b0);
            if (k == 41) check("both_resume_41", up_pulse, 1'b1);
        end
        check_int("both_up_pulses", up_cnt, 7);
        check_int("both_down_pulses", dn_cnt, 0);

        // Reset in the middle of repeating.
        up_raw = 1'b0;
        tick(25);
        rst_n = 1'b0;
        #1;
        check("midrst_lvl", up_lvl, 1'b1);
        check("midrst_pulse", up_pulse, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("midrst_lvl_hold", up_lvl, 1'b1);
        tick(1);
        check("midrst_lvl_fall", up_lvl, 1'b0);
        check("midrst_fresh_pulse", up_pulse, 1'b1);
        tick(9);
        check("midrst_gap", up_pulse, 1'b0);
        tick(1);
        check("midrst_repeat", up_pulse, 1'b1);
        up_raw = 1'b1;
        tick(12);

        // Randomized activity; the negedge compare checks every cycle.
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 14) == 0) begin
                rst_n = 1'b0;
                tick($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            up_raw   = 1'($urandom_range(0, 1));
            down_raw = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 40));
        end
        up_raw = 1'b1;
        down_raw = 1'b1;
        tick(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
